ixu_issue: RTL and testbench

Issue stage of the integer execution unit; the producer side of the IXU ALU operand/opcode interface. Accepts register-read RV32I OP and OP-IMM instructions through a valid/ready handshake and buffers them in a small FIFO. It decodes each one into the 4-bit ALU op, X and Y, drives the combinational ALU from a registered stage, and captures the result into a tagged output register with backpressure.

---
 rtl/ixu_pkg.sv | 60 ++++++
 rtl/ixu_issue_fifo.sv | 70 +++++++
 rtl/ixu_issue.sv | 186 ++++++++++++++++++
 tb/tb_ixu_issue.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ixu_pkg.sv
// Shared ALU op encoding, opcode/funct7 constants and the OP/OP-IMM decoder
// used by the IXU issue stage.
package ixu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    is_shift;
    logic    illegal;
  } dec_t;

  // Only the opcode, funct3 and funct7 fields matter to the decode; illegal
  // encodings always come back as ALU_ADD so the ALU never sees a stray op.
  function automatic dec_t decode(input logic [6:0] opc,
                                  input logic [2:0] f3,
                                  input logic [6:0] f7);
    dec_t d;
    logic is_op;
    logic is_imm;
    logic f7_ok;
    is_op      = (opc == OPC_OP);
    is_imm     = (opc == OPC_OP_IMM);
    f7_ok      = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    d.use_imm  = is_imm;
    d.is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    d.illegal  = !(is_op || is_imm) || (is_op && !f7_ok) || (is_imm && d.is_shift && !f7_ok);
    d.op       = ALU_ADD;
    case (f3)
      3'b000:  d.op = (is_op && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
      3'b001:  d.op = ALU_SLL;
      3'b010:  d.op = ALU_SLT;
      3'b011:  d.op = ALU_SLTU;
      3'b100:  d.op = ALU_XOR;
      3'b101:  d.op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110:  d.op = ALU_OR;
      default: d.op = ALU_AND;
    endcase
    if (d.illegal) d.op = ALU_ADD;
    return d;
  endfunction

endpackage

// File: rtl/ixu_issue_fifo.sv
// Synchronous FIFO for the issue stage: power-of-two DEPTH, pointers wrap
// naturally, push ignored when full and pop ignored when empty.
module ixu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every output of always_comb gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever read after
  // a push wrote it, and the cleared pointers/count hide any stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ixu_issue.sv
// IXU issue stage: FIFO -> decode register D (drives alu_*) -> result register W (drives out_*).
// Optional IXU_ISSUE_BYPASS_EN: an instruction may skip an empty FIFO straight into D.
module ixu_issue
  import ixu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_x,
  output logic [31:0]      alu_y,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Only the instruction fields the decoder needs are buffered.
  typedef struct packed {
    logic [11:0]      imm;
    logic [2:0]       f3;
    logic [6:0]       opc;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  entry_t           in_entry;
  entry_t           head;
  entry_t           src;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_nxt;
  logic             accept;
  logic             bypass;
  logic             src_valid;
  logic             w_load;
  logic             d_load;
  dec_t             dec;
  logic [31:0]      y_raw;
  logic             unused_instr;

  logic             in_ready_q, in_ready_d;
  logic             d_valid_q, d_valid_d;
  alu_op_e          d_op_q, d_op_d;
  logic [31:0]      d_x_q, d_x_d;
  logic [31:0]      d_y_q, d_y_d;
  logic [TAG_W-1:0] d_tag_q, d_tag_d;
  logic             d_illegal_q, d_illegal_d;
  logic             w_valid_q, w_valid_d;
  logic [31:0]      w_result_q, w_result_d;
  logic [TAG_W-1:0] w_tag_q, w_tag_d;
  logic             w_illegal_q, w_illegal_d;

  assign in_entry = '{imm: in_instr[31:20], f3: in_instr[14:12], opc: in_instr[6:0],
                      rs1: in_rs1_val, rs2: in_rs2_val, tag: in_tag};
  assign unused_instr = ^{in_instr[19:15], in_instr[11:7]};

  ixu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Handshake and stall control; in_ready is registered from the next FIFO count.
  always_comb begin
    accept = in_valid && in_ready_q;
    w_load = !w_valid_q || out_ready;
    d_load = !d_valid_q || w_load;
`ifdef IXU_ISSUE_BYPASS_EN
    bypass = accept && fifo_empty && d_load;
`else
    bypass = 1'b0;
`endif
    fifo_push  = accept && !bypass && !fifo_full;
    fifo_pop   = d_load && !fifo_empty;
    src_valid  = fifo_pop || bypass;
    src        = fifo_empty ? in_entry : head;
    count_nxt  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    in_ready_d = (count_nxt != CNT_W'(DEPTH));
  end

  always_comb begin
    dec   = decode(src.opc, src.f3, src.imm[11:5]);
    y_raw = dec.use_imm ? {{20{src.imm[11]}}, src.imm} : src.rs2;
    if (dec.is_shift) y_raw = {27'b0, y_raw[4:0]};
  end

  always_comb begin
    d_valid_d   = d_valid_q;
    d_op_d      = d_op_q;
    d_x_d       = d_x_q;
    d_y_d       = d_y_q;
    d_tag_d     = d_tag_q;
    d_illegal_d = d_illegal_q;
    w_valid_d   = w_valid_q;
    w_result_d  = w_result_q;
    w_tag_d     = w_tag_q;
    w_illegal_d = w_illegal_q;

    if (d_load) begin
      d_valid_d = src_valid;
      if (src_valid) begin
        d_op_d      = dec.op;
        d_x_d       = dec.illegal ? '0 : src.rs1;
        d_y_d       = dec.illegal ? '0 : y_raw;
        d_tag_d     = src.tag;
        d_illegal_d = dec.illegal;
      end
    end

    // W only changes when it can load, which keeps out_* stable under backpressure.
    if (w_load) begin
      w_valid_d = d_valid_q;
      if (d_valid_q) begin
        w_result_d  = d_illegal_q ? '0 : alu_result;
        w_tag_d     = d_tag_q;
        w_illegal_d = d_illegal_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      d_op_q      <= ALU_ADD;
      d_x_q       <= '0;
      d_y_q       <= '0;
      d_tag_q     <= '0;
      d_illegal_q <= 1'b0;
      w_valid_q   <= 1'b0;
      w_result_q  <= '0;
      w_tag_q     <= '0;
      w_illegal_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      d_valid_q   <= d_valid_d;
      d_op_q      <= d_op_d;
      d_x_q       <= d_x_d;
      d_y_q       <= d_y_d;
      d_tag_q     <= d_tag_d;
      d_illegal_q <= d_illegal_d;
      w_valid_q   <= w_valid_d;
      w_result_q  <= w_result_d;
      w_tag_q     <= w_tag_d;
      w_illegal_q <= w_illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_op      = d_op_q;
  assign alu_x       = d_x_q;
  assign alu_y       = d_y_q;
  assign out_valid   = w_valid_q;
  assign out_result  = w_result_q;
  assign out_tag     = w_tag_q;
  assign out_illegal = w_illegal_q;

endmodule

// File: tb/tb_ixu_issue.sv
// Bench for ixu_issue: queue-based reference of the FIFO/D/W pipeline checked every cycle,
// plus literal directed cases. Honours IXU_ISSUE_BYPASS_EN when defined.
module tb_ixu_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
`ifdef IXU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [31:0]      in_rs1_val = '0;
  logic [31:0]      in_rs2_val = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      alu_x;
  logic [31:0]      alu_y;
  logic [3:0]       alu_op;
  logic [31:0]      alu_result;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ixu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_tag(in_tag),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x ^ y;
      4'd3:    return x | y;
      4'd4:    return x & y;
      4'd5:    return x << y[4:0];
      4'd6:    return x >> y[4:0];
      4'd7:    return 32'($signed(x) >>> y[4:0]);
      4'd8:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:    return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_x, alu_y);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [3:0]       op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } item_t;

  // Expected ALU operands and result of one instruction, straight from the ISA rules.
  function automatic item_t make_item(logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                                      logic [TAG_W-1:0] t);
    item_t it;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit is_op, is_imm, shift, bad;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    is_op  = (opc == 7'b0110011);
    is_imm = (opc == 7'b0010011);
    shift  = (f3 == 3'd1) || (f3 == 3'd5);
    bad    = !(is_op || is_imm);
    if ((is_op || (is_imm && shift)) &&
        !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
    case (f3)
      3'd0:    it.op = (is_op && f7 == 7'h20) ? 4'd1 : 4'd0;
      3'd1:    it.op = 4'd5;
      3'd2:    it.op = 4'd8;
      3'd3:    it.op = 4'd9;
      3'd4:    it.op = 4'd2;
      3'd5:    it.op = (f7 == 7'h20) ? 4'd7 : 4'd6;
      3'd6:    it.op = 4'd3;
      default: it.op = 4'd4;
    endcase
    it.x = a;
    it.y = is_op ? b : {{20{ins[31]}}, ins[31:20]};
    if (shift) it.y = it.y & 32'h1f;
    if (bad) begin
      it.op = 4'd0; it.x = '0; it.y = '0;
    end
    it.res = bad ? 32'd0 : ref_alu(it.op, it.x, it.y);
    it.tag = t;
    it.ill = bad;
    return it;
  endfunction

  // Reference occupancy: FIFO queue plus D and W slots advanced by the stall rules.
  item_t m_fifo[$];
  item_t m_d, m_w, m_new;
  bit    m_d_v, m_w_v, m_rdy, m_acc, m_taken, m_wl, m_dl, started;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      m_fifo.delete();
      m_d_v = 1'b0; m_w_v = 1'b0; m_rdy = 1'b0;
    end else begin
      m_acc   = in_valid && m_rdy;
      m_taken = 1'b0;
      m_new   = make_item(in_instr, in_rs1_val, in_rs2_val, in_tag);
      m_wl    = !m_w_v || out_ready;
      m_dl    = !m_d_v || m_wl;
      if (m_wl) begin
        m_w_v = m_d_v;
        m_w   = m_d;
      end
      if (m_dl) begin
        if (m_fifo.size() > 0) begin
          m_d = m_fifo.pop_front(); m_d_v = 1'b1;
        end else if (BYP && m_acc) begin
          m_d = m_new; m_d_v = 1'b1; m_taken = 1'b1;
        end else begin
          m_d_v = 1'b0;
        end
      end
      if (m_acc && !m_taken) m_fifo.push_back(m_new);
      m_rdy = (m_fifo.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc out_valid", 32'(out_valid), 32'(m_w_v));
      check("cyc in_ready", 32'(in_ready), 32'(m_rdy));
      if (m_w_v) begin
        check("cyc out_result", out_result, m_w.res);
        check("cyc out_tag", 32'(out_tag), 32'(m_w.tag));
        check("cyc out_illegal", 32'(out_illegal), 32'(m_w.ill));
      end
      if (m_d_v) begin
        check("cyc alu_op", 32'(alu_op), 32'(m_d.op));
        check("cyc alu_x", alu_x, m_d.x);
        check("cyc alu_y", alu_y, m_d.y);
      end
    end
  end

  // One instruction through an idle pipeline with literal expectations; called at a negedge.
  task automatic directed(input string nm, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] t,
                          input logic [3:0] e_op, input logic [31:0] e_x, input logic [31:0] e_y,
                          input logic [31:0] e_res, input logic e_ill);
    int  j;
    bit  seen;
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_instr = ins; in_rs1_val = a; in_rs2_val = b; in_tag = t;
    @(posedge clk);
    seen = 1'b0;
    j = 0;
    while (!seen && j < 8) begin
      j++;
      @(negedge clk);
      if (j == 1) in_valid = 1'b0;
      if (j == LAT) begin
        check({nm, " alu_op"}, 32'(alu_op), 32'(e_op));
        check({nm, " alu_x"}, alu_x, e_x);
        check({nm, " alu_y"}, alu_y, e_y);
      end
      if (out_valid) begin
        seen = 1'b1;
        check({nm, " latency"}, 32'(j), 32'(LAT + 1));
        check({nm, " out_result"}, out_result, e_res);
        check({nm, " out_tag"}, 32'(out_tag), 32'(t));
        check({nm, " out_illegal"}, 32'(out_illegal), 32'(e_ill));
      end
    end
    if (!seen) check({nm, " result timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 7);
    if (sel < 3) begin
      w[6:0] = 7'b0110011;
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        default: ;
      endcase
    end else if (sel < 6) begin
      w[6:0] = 7'b0010011;
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  next_tag;
    bit  rdy;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset out_tag", 32'(out_tag), 32'd0);
    check("reset out_illegal", 32'(out_illegal), 32'd0);
    check("reset alu_x", alu_x, 32'd0);
    check("reset alu_y", alu_y, 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    directed("add", 32'h0000_0033, 32'd5, 32'd7, 6'd3, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    directed("sll", 32'h0000_1033, 32'd1, 32'h21, 6'd4, 4'd5, 32'd1, 32'd1, 32'd2, 1'b0);
    directed("sltiu", 32'hFFF0_3013, 32'd5, 32'h0000_DEAD, 6'd5, 4'd9, 32'd5, 32'hFFFF_FFFF,
             32'd1, 1'b0);
    directed("sub", 32'h4000_0033, 32'd3, 32'd5, 6'd6, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    directed("srai", 32'h4030_5013, 32'h8000_0000, 32'd0, 6'd9, 4'd7, 32'h8000_0000, 32'd3,
             32'hF000_0000, 1'b0);
    directed("load", 32'h0000_0003, 32'd9, 32'd9, 6'd7, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    directed("op alt xor", 32'h4000_4033, 32'd1, 32'd2, 6'd8, 4'd0, 32'd0, 32'd0, 32'd0, 1'b1);

    // Capacity: with out_ready low exactly DEPTH+2 instructions are taken.
    out_ready = 1'b0;
    next_tag  = 0;
    repeat (12) begin
      if (next_tag < 8) begin
        in_valid = 1'b1; in_tag = TAG_W'(next_tag); in_instr = 32'h0000_0033;
        in_rs1_val = $urandom; in_rs2_val = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) next_tag++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("capacity accepted", 32'(next_tag), 32'(DEPTH + 2));
    check("capacity in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("drain out_valid", 32'(out_valid), 32'd1);
      check("drain out_tag", 32'(out_tag), 32'(i));
      @(negedge clk);
    end
    check("drain empty", 32'(out_valid), 32'd0);

    // Reset with three instructions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = TAG_W'(20 + i); in_instr = 32'h0000_6033;
      in_rs1_val = $urandom; in_rs2_val = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst alu_op", 32'(alu_op), 32'd0);
    check("midrst alu_x", alu_x, 32'd0);
    check("midrst alu_y", alu_y, 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst in_ready after", 32'(in_ready), 32'd1);
    repeat (5) begin
      check("midrst no stale result", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Random traffic with random backpressure.
    repeat (800) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = rand_instr();
      in_rs1_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_rs2_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      in_tag     = TAG_W'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 4) @(negedge clk);
    check("final drained", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
